sincronizacion_vga: RTL and testbench



---
 rtl/sincronizacion_vga_if.sv | 18 +
 rtl/sincronizacion_vga.sv | 91 +++++++++
 tb/tb_sincronizacion_vga.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sincronizacion_vga_if.sv
// rtl/sincronizacion_vga_if.sv - coordinate and sync bundle from the VGA timing generator
interface sincronizacion_vga_if;
   logic [9:0] Qh;
   logic [9:0] Qv;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       pixel_tick;
   logic       fin_cuadro;

   modport master (
      output Qh, Qv, hsync, vsync, video_on, pixel_tick, fin_cuadro
   );

   modport slave (
      input Qh, Qv, hsync, vsync, video_on, pixel_tick, fin_cuadro
   );
endinterface

// File: rtl/sincronizacion_vga.sv
// rtl/sincronizacion_vga.sv - 640x480@60 VGA pixel divider, counters and sync generation
module sincronizacion_vga #(
   parameter int DIV       = 4,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic                 reloj,
   input  logic                 resetM,
   sincronizacion_vga_if.master vga
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       qh;
   logic [9:0]       qv;
   logic [9:0]       qh_next;
   logic [9:0]       qv_next;
   logic             tick;
   logic             line_end;
   logic             hsync_r;
   logic             vsync_r;
   logic             video_on_r;

   // Tick is decoded from the registered count so it is a clean one-cycle strobe
   assign tick     = (div_cnt == DIV_LAST);
   assign line_end = tick && (qh == H_LAST);

   // Next coordinates; shared by the counters and the sync/blank registers
   always_comb begin
      qh_next = qh;
      qv_next = qv;
      if (tick) begin
         if (qh == H_LAST) qh_next = '0;
         else              qh_next = qh + 10'd1;
      end
      if (line_end) begin
         if (qv == V_LAST) qv_next = '0;
         else              qv_next = qv + 10'd1;
      end
   end

   // Pixel-rate divider, wraps on the tick cycle
   always_ff @(posedge reloj) begin
      if (resetM)    div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DIV_W'(1);
   end

   // Counters plus syncs/blank loaded from next-state values so they line up with Qh/Qv
   always_ff @(posedge reloj) begin
      if (resetM) begin
         qh         <= '0;
         qv         <= '0;
         hsync_r    <= 1'b1;
         vsync_r    <= 1'b1;
         video_on_r <= 1'b1;
      end else begin
         qh         <= qh_next;
         qv         <= qv_next;
         hsync_r    <= !((qh_next >= HS_START) && (qh_next < HS_END));
         vsync_r    <= !((qv_next >= VS_START) && (qv_next < VS_END));
         video_on_r <= (qh_next < H_VIS) && (qv_next < V_VIS);
      end
   end

   assign vga.Qh         = qh;
   assign vga.Qv         = qv;
   assign vga.hsync      = hsync_r;
   assign vga.vsync      = vsync_r;
   assign vga.video_on   = video_on_r;
   assign vga.pixel_tick = tick;
   assign vga.fin_cuadro = line_end && (qv == V_LAST);
endmodule

// File: tb/tb_sincronizacion_vga.sv
// tb/tb_sincronizacion_vga.sv - scoreboard bench for the VGA timing generator
module tb_sincronizacion_vga;
   logic reloj = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   always #5 reloj = ~reloj;

   sincronizacion_vga_if vga_a ();
   sincronizacion_vga_if vga_b ();

   sincronizacion_vga #(.DIV(4)) dut_a (
      .reloj  (reloj),
      .resetM (rst_a),
      .vga    (vga_a)
   );

   sincronizacion_vga #(.DIV(2), .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) dut_b (
      .reloj  (reloj),
      .resetM (rst_b),
      .vga    (vga_b)
   );

   typedef struct {
      int cyc;
      int qh;
      int qv;
      bit hs;
      bit vs;
      bit von;
      bit fin;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   cyc    = 0;
   int   t_a    = 0;
   int   t_b    = 0;
   bit   live_a = 0;
   bit   live_b = 0;
   int   n_chk  = 0;
   int   n_err  = 0;

   // Reference: pixel index is elapsed clocks / DIV; coordinates are that index in row-major order
   function automatic exp_t model(int t, int div, int vdisp, int vfront, int vsync, int vback, int c);
      exp_t e;
      int   p;
      int   vt;
      vt    = vdisp + vfront + vsync + vback;
      p     = t / div;
      e.cyc = c;
      e.qh  = p % 800;
      e.qv  = (p / 800) % vt;
      e.hs  = !(e.qh >= 656 && e.qh < 752);
      e.vs  = !(e.qv >= vdisp + vfront && e.qv < vdisp + vfront + vsync);
      e.von = (e.qh < 640) && (e.qv < vdisp);
      e.fin = (e.qh == 799) && (e.qv == vt - 1);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic cmp_item(input string name, input exp_t e, input logic [9:0] qh, input logic [9:0] qv,
                           input logic hs, input logic vs, input logic von, input logic fin);
      n_chk++;
      if (cyc != e.cyc || qh !== 10'(e.qh) || qv !== 10'(e.qv) || hs !== e.hs || vs !== e.vs ||
          von !== e.von || fin !== e.fin) begin
         n_err++;
         $display("FAIL %s: got cyc=%0d Qh=%0d Qv=%0d hs=%b vs=%b von=%b fin=%b expected cyc=%0d Qh=%0d Qv=%0d hs=%b vs=%b von=%b fin=%b",
                  name, cyc, qh, qv, hs, vs, von, fin, e.cyc, e.qh, e.qv, e.hs, e.vs, e.von, e.fin);
      end
   endtask

   task automatic check_reset(input string name, input logic [9:0] qh, input logic [9:0] qv, input logic hs,
                              input logic vs, input logic von, input logic tk, input logic fin);
      check({name, "_Qh"}, 32'(qh), 0);
      check({name, "_Qv"}, 32'(qv), 0);
      check({name, "_hsync"}, 32'(hs), 1);
      check({name, "_vsync"}, 32'(vs), 1);
      check({name, "_video_on"}, 32'(von), 1);
      check({name, "_tick"}, 32'(tk), 0);
      check({name, "_fin"}, 32'(fin), 0);
   endtask

   // Stimulus-side predictor: pushes one expected item for every cycle a tick is due
   initial forever begin
      @(posedge reloj);
      cyc = cyc + 1;
      if (rst_a) begin t_a = 0; live_a = 1; end else t_a = t_a + 1;
      if (rst_b) begin t_b = 0; live_b = 1; end else t_b = t_b + 1;
      if (live_a && !rst_a && (t_a % 4 == 3)) q_a.push_back(model(t_a, 4, 480, 10, 2, 33, cyc));
      if (live_b && !rst_b && (t_b % 2 == 1)) q_b.push_back(model(t_b, 2, 6, 1, 2, 2, cyc));
   end

   // Monitor: pops on every DUT tick/frame pulse; leftovers mean a tick went missing
   initial forever begin
      @(negedge reloj);
      if (vga_a.pixel_tick === 1'b1 || vga_a.fin_cuadro === 1'b1) begin
         if (q_a.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL a_unexpected_tick: got tick at cyc=%0d expected none", cyc);
         end else begin
            cmp_item("a_pixel", q_a.pop_front(), vga_a.Qh, vga_a.Qv, vga_a.hsync, vga_a.vsync,
                     vga_a.video_on, vga_a.fin_cuadro);
         end
      end
      if (vga_b.pixel_tick === 1'b1 || vga_b.fin_cuadro === 1'b1) begin
         if (q_b.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL b_unexpected_tick: got tick at cyc=%0d expected none", cyc);
         end else begin
            cmp_item("b_pixel", q_b.pop_front(), vga_b.Qh, vga_b.Qv, vga_b.hsync, vga_b.vsync,
                     vga_b.video_on, vga_b.fin_cuadro);
         end
      end
      while (q_a.size() > 0) begin
         n_chk++; n_err++;
         $display("FAIL a_missing_tick: got no tick expected tick at cyc=%0d", q_a[0].cyc);
         void'(q_a.pop_front());
      end
      while (q_b.size() > 0) begin
         n_chk++; n_err++;
         $display("FAIL b_missing_tick: got no tick expected tick at cyc=%0d", q_b[0].cyc);
         void'(q_b.pop_front());
      end
   end

   initial begin
      fork
         // Instance A: DIV=4, full geometry; reset release, first line, random resets
         begin
            int hs_low;
            int von_cnt;
            repeat (5) @(negedge reloj);
            check_reset("a_reset_hold", vga_a.Qh, vga_a.Qv, vga_a.hsync, vga_a.vsync, vga_a.video_on,
                        vga_a.pixel_tick, vga_a.fin_cuadro);
            rst_a   = 1'b0;
            hs_low  = (vga_a.hsync === 1'b0) ? 1 : 0;
            von_cnt = (vga_a.video_on === 1'b1) ? 1 : 0;
            for (int k = 1; k <= 3200; k++) begin
               @(negedge reloj);
               if (k == 2) check("a_tick_c2", 32'(vga_a.pixel_tick), 0);
               if (k == 3) check("a_tick_c3", 32'(vga_a.pixel_tick), 1);
               if (k == 4) check("a_qh_c4", 32'(vga_a.Qh), 1);
               if (k == 3199) begin
                  check("a_qh_c3199", 32'(vga_a.Qh), 799);
                  check("a_qv_c3199", 32'(vga_a.Qv), 0);
               end
               if (k < 3200) begin
                  if (vga_a.hsync === 1'b0) hs_low++;
                  if (vga_a.video_on === 1'b1) von_cnt++;
               end else begin
                  check("a_qh_wrap", 32'(vga_a.Qh), 0);
                  check("a_qv_wrap", 32'(vga_a.Qv), 1);
               end
            end
            check("a_hsync_low_clocks", hs_low, 384);
            check("a_video_on_clocks", von_cnt, 2560);
            repeat (3) begin
               repeat ($urandom_range(3000, 50)) @(negedge reloj);
               rst_a = 1'b1;
               repeat ($urandom_range(4, 1)) @(negedge reloj);
               check_reset("a_rand_reset", vga_a.Qh, vga_a.Qv, vga_a.hsync, vga_a.vsync, vga_a.video_on,
                           vga_a.pixel_tick, vga_a.fin_cuadro);
               rst_a = 1'b0;
            end
            repeat (100) @(negedge reloj);
         end
         // Instance B: DIV=2, short frame; full frame, mid-frame reset inside both syncs
         begin
            int vs_low;
            int fin_cnt;
            int fin_k;
            int w;
            repeat (5) @(negedge reloj);
            rst_b   = 1'b0;
            vs_low  = 0;
            fin_cnt = 0;
            fin_k   = -1;
            for (int k = 1; k <= 17600; k++) begin
               @(negedge reloj);
               if (k == 1) check("b_tick_c1", 32'(vga_b.pixel_tick), 1);
               if (k == 2) check("b_tick_c2", 32'(vga_b.pixel_tick), 0);
               if (k == 1599) check("b_qv_c1599", 32'(vga_b.Qv), 0);
               if (k == 1600) begin
                  check("b_qh_line", 32'(vga_b.Qh), 0);
                  check("b_qv_line", 32'(vga_b.Qv), 1);
               end
               if (k < 17600) begin
                  if (vga_b.pixel_tick === 1'b1 && vga_b.vsync === 1'b0) vs_low++;
                  if (vga_b.fin_cuadro === 1'b1) begin fin_cnt++; fin_k = k; end
               end else begin
                  check("b_frame_qh", 32'(vga_b.Qh), 0);
                  check("b_frame_qv", 32'(vga_b.Qv), 0);
               end
            end
            check("b_vsync_low_ticks", vs_low, 1600);
            check("b_fin_count", fin_cnt, 1);
            check("b_fin_cycle", fin_k, 17599);
            w = 0;
            while (!(vga_b.Qh === 10'd700 && vga_b.Qv === 10'd8) && w < 20000) begin
               @(negedge reloj);
               w++;
            end
            check("b_reach_700_8", 32'(w < 20000), 1);
            check("b_hsync_mid", 32'(vga_b.hsync), 0);
            check("b_vsync_mid", 32'(vga_b.vsync), 0);
            rst_b = 1'b1;
            @(negedge reloj);
            check_reset("b_mid_reset", vga_b.Qh, vga_b.Qv, vga_b.hsync, vga_b.vsync, vga_b.video_on,
                        vga_b.pixel_tick, vga_b.fin_cuadro);
            rst_b = 1'b0;
            @(negedge reloj);
            check("b_restart_tick", 32'(vga_b.pixel_tick), 1);
            @(negedge reloj);
            check("b_restart_qh", 32'(vga_b.Qh), 1);
            repeat (2000) @(negedge reloj);
         end
      join
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
